sdpram_fifo: RTL and testbench
==============================

SDPRAM_FIFO -- requirements
Module: sdpram_fifo

Interface
REQ-001 SHALL have parameter widthad_a, default 8: address width; depth = 2^widthad_a entries.
REQ-002 SHALL have parameter width_a, default 8: data word width.
REQ-003 SHALL have parameter af_margin, default 2: almost_full asserts when free entries <= af_margin.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous flush.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port wr_data  input  width_a  write word.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port rd_data  output  width_a  read word, registered.
REQ-011 SHALL have port rd_valid  output  1  rd_data holds a newly read word this cycle.
REQ-012 SHALL have port full  output  1  level == depth.
REQ-013 SHALL have port empty  output  1  level == 0.
REQ-014 SHALL have port almost_full  output  1  level >= depth - af_margin.
REQ-015 SHALL have port level  output  widthad_a+1  stored word count.
REQ-016 SHALL have port overflow  output  1  sticky: write attempted while full.
REQ-017 SHALL have port underflow  output  1  sticky: read attempted while empty.

Function
REQ-018 Storage SHALL be an inferred simple-dual-port array (one write port, one registered read port), not reset, no output mux beyond the read register.
REQ-019 Write accepted iff wr_en && !full; word stored at wr_ptr, wr_ptr increments modulo depth.
REQ-020 Read accepted iff rd_en && !empty; word at rd_ptr loaded into rd_data at that edge, rd_ptr increments modulo depth; rd_valid = 1 the following cycle only.
REQ-021 Read latency SHALL be exactly 1 cycle from the accepting edge; rd_data SHALL hold its last value when no read is accepted.
REQ-022 Simultaneous accepted write and read: level unchanged, both pointers advance.
REQ-023 Write while full SHALL be rejected even if a read is accepted that cycle; read while empty SHALL be rejected even if a write is accepted that cycle (no fall-through).
REQ-024 level, full, empty, almost_full SHALL be registered and consistent in the same cycle; pointer wrap SHALL not disturb them.
REQ-025 clear SHALL take priority over wr_en/rd_en: pointers, level and rd_valid go to 0, empty = 1, storage and rd_data untouched.

Reset
REQ-026 On reset_n low, immediately and regardless of clock: wr_ptr = rd_ptr = 0, level = 0, empty = 1, full = 0, almost_full = 0 (or 1 if af_margin >= depth), rd_valid = 0, rd_data = 0, overflow = underflow = 0.
REQ-027 Reset mid-operation SHALL discard all stored words; first accepted write after release goes to address 0.

Configuration
REQ-028 Macro SDPRAM_FIFO_ERR_EN defined: overflow set on any cycle with wr_en && full, underflow on rd_en && empty; both sticky until clear or reset.
REQ-029 Macro SDPRAM_FIFO_ERR_EN undefined: overflow and underflow SHALL be constant 0 and their flops SHALL not exist.

Verification (widthad_a = 2, width_a = 8, af_margin = 1)
REQ-030 Write 0x11,0x22,0x33,0x44 on consecutive cycles -> level 1..4, almost_full at level 3, full at level 4, empty cleared after first write.
REQ-031 From full, read 4 times -> rd_data 0x11,0x22,0x33,0x44 each one cycle after rd_en with rd_valid pulses, empty at end.
REQ-032 Full FIFO, wr_en=1 rd_en=1 same cycle -> oldest word read, write rejected, level 3, overflow = 1 (ERR_EN) / 0 (no ERR_EN).
REQ-033 Empty FIFO, wr_en=1 rd_en=1 -> write accepted, no rd_valid, level 1, underflow = 1 (ERR_EN).
REQ-034 Stream 10 words with continuous reads after 2 cycles -> in-order data across pointer wrap, level never exceeds 3.
REQ-035 Level 3, assert clear with wr_en=1 -> level 0, empty 1, error flags 0; separately drop reset_n mid-stream -> all outputs per REQ-026 without a clock edge.

Source files
------------

// File: rtl/sdpram_fifo.sv
// sdpram_fifo: single-clock FIFO built on an inferred simple-dual-port RAM
// with one write port and one registered read port. The read port has no
// fall-through: a word shows up on rd_data one cycle after its read is
// accepted, and rd_valid marks that cycle.
//
// Optional feature macro: SDPRAM_FIFO_ERR_EN
//   defined   -> sticky overflow/underflow flags (cleared by clear or reset)
//   undefined -> overflow/underflow tied to 0, no flops
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   clear        in   synchronous flush (beats wr_en/rd_en)
//   wr_en        in   write request
//   wr_data      in   write word [width_a]
//   rd_en        in   read request
//   rd_data      out  registered read word [width_a]
//   rd_valid     out  rd_data was loaded by the previous edge
//   full         out  level == depth
//   empty        out  level == 0
//   almost_full  out  level >= depth - af_margin
//   level        out  stored word count [widthad_a+1]
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
module sdpram_fifo #(
  parameter int widthad_a = 8,
  parameter int width_a   = 8,
  parameter int af_margin = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [width_a-1:0]   wr_data,
  input  logic                 rd_en,
  output logic [width_a-1:0]   rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [widthad_a:0]   level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << widthad_a;
  localparam logic [widthad_a:0]   DEPTH_LVL = (widthad_a+1)'(DEPTH);
  // A margin at or beyond the depth makes almost_full permanently true.
  localparam int AF_THR = (af_margin >= DEPTH) ? 0 : (DEPTH - af_margin);
  localparam logic [widthad_a:0]   AF_LVL    = (widthad_a+1)'(AF_THR);
  localparam logic                 AF_RST    = (AF_THR == 0);
  localparam logic [widthad_a-1:0] PTR_ONE   = widthad_a'(1'b1);
  localparam logic [widthad_a:0]   LVL_ONE   = (widthad_a+1)'(1'b1);
  localparam logic [widthad_a:0]   LVL_ZERO  = '0;

  logic [width_a-1:0]   mem_r [DEPTH];
  logic [widthad_a-1:0] wr_ptr_r;
  logic [widthad_a-1:0] rd_ptr_r;
  logic [widthad_a:0]   level_r;
  logic [widthad_a:0]   level_nxt_s;
  logic                 full_r;
  logic                 empty_r;
  logic                 af_r;
  logic                 rd_valid_r;
  logic [width_a-1:0]   rd_data_r;
  logic                 wr_acc_s;
  logic                 rd_acc_s;

  // Acceptance uses the registered flags only, so a same-cycle read never
  // frees room for a write and a same-cycle write never feeds a read.
  assign wr_acc_s = wr_en && !full_r  && !clear;
  assign rd_acc_s = rd_en && !empty_r && !clear;

  // Next stored-word count from the accepted write/read pair.
  always_comb begin
    level_nxt_s = level_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Storage write port; the array is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Registered read port; holds its value whenever no read is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_r <= '0;
    end else if (rd_acc_s) begin
      rd_data_r <= mem_r[rd_ptr_r];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  // Pointers, level and status flags, all derived from the same next level
  // so they always agree within a cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= LVL_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      af_r       <= AF_RST;
      rd_valid_r <= 1'b0;
    end else if (clear) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= LVL_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      af_r       <= AF_RST;
      rd_valid_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_acc_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r   <= rd_acc_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      level_r    <= level_nxt_s;
      full_r     <= (level_nxt_s == DEPTH_LVL);
      empty_r    <= (level_nxt_s == LVL_ZERO);
      af_r       <= (level_nxt_s >= AF_LVL);
      rd_valid_r <= rd_acc_s;
    end
  end

`ifdef SDPRAM_FIFO_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; any attempt counts, accepted or not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (clear) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  || (wr_en && full_r);
      underflow_r <= underflow_r || (rd_en && empty_r);
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign almost_full = af_r;
  assign level       = level_r;

endmodule

// File: tb/tb_sdpram_fifo.sv
// Directed self-checking bench for sdpram_fifo (depth 4, 8-bit, af_margin 1).
module tb_sdpram_fifo;

  logic       clock;
  logic       reset_n;
  logic       clear;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [2:0] level;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

`ifdef SDPRAM_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  sdpram_fifo #(.widthad_a(2), .width_a(8), .af_margin(1)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs, wait for the edge, sample 1 ns later.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; wr_data = d; rd_en = r; clear = c;
    @(posedge clock); #1;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    #12;
    checks++;
    if ({level, empty, full, almost_full, rd_valid, rd_data, overflow, underflow}
        !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: level=%0d empty=%b full=%b af=%b rv=%b rd=%h ov=%b un=%b required 0 1 0 0 0 00 0 0",
               level, empty, full, almost_full, rd_valid, rd_data, overflow, underflow);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_fill;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, vals[i], 1'b0, 1'b0);
      checks++;
      if ({level, empty, full, almost_full} !==
          {3'(i+1), 1'b0, (i == 3), (i >= 2)}) begin
        errors++;
        $display("FAIL fill_%0d: level=%0d empty=%b full=%b af=%b required %0d 0 %b %b",
                 i, level, empty, full, almost_full, i+1, (i == 3), (i >= 2));
      end
    end
  endtask

  task automatic test_drain;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if ({rd_valid, rd_data, level} !== {1'b1, vals[i], 3'(3-i)}) begin
        errors++;
        $display("FAIL drain_%0d: rv=%b rd=%h level=%0d required 1 %h %0d",
                 i, rd_valid, rd_data, level, vals[i], 3-i);
      end
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({rd_valid, rd_data, empty, full, underflow} !== {1'b0, 8'h44, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL drain_hold: rv=%b rd=%h empty=%b full=%b un=%b required 0 44 1 0 0",
               rd_valid, rd_data, empty, full, underflow);
    end
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    checks++;
    if ({full, level} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL full_rw_pre: full=%b level=%0d required 1 4", full, level);
    end
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    checks++;
    if ({rd_valid, rd_data, level, full, almost_full, overflow} !==
        {1'b1, 8'hA0, 3'd3, 1'b0, 1'b1, ERR}) begin
      errors++;
      $display("FAIL full_rw: rv=%b rd=%h level=%0d full=%b af=%b ov=%b required 1 a0 3 0 1 %b",
               rd_valid, rd_data, level, full, almost_full, overflow, ERR);
    end
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, 8'hA0 + 8'(i)}) begin
        errors++;
        $display("FAIL full_rw_rest_%0d: rv=%b rd=%h required 1 %h", i, rd_valid, rd_data, 8'hA0 + 8'(i));
      end
    end
    checks++;
    if ({empty, overflow} !== {1'b1, ERR}) begin
      errors++;
      $display("FAIL full_rw_sticky: empty=%b ov=%b required 1 %b", empty, overflow, ERR);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if ({overflow, level, empty} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL full_rw_clear: ov=%b level=%0d empty=%b required 0 0 1", overflow, level, empty);
    end
  endtask

  task automatic test_empty_rw;
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    checks++;
    if ({rd_valid, rd_data, level, empty, underflow} !== {1'b0, 8'hA3, 3'd1, 1'b0, ERR}) begin
      errors++;
      $display("FAIL empty_rw: rv=%b rd=%h level=%0d empty=%b un=%b required 0 a3 1 0 %b",
               rd_valid, rd_data, level, empty, underflow, ERR);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({rd_valid, rd_data, empty} !== {1'b1, 8'h55, 1'b1}) begin
      errors++;
      $display("FAIL empty_rw_read: rv=%b rd=%h empty=%b required 1 55 1", rd_valid, rd_data, empty);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_stream;
    int mlvl = 0;
    int sent = 0;
    int got  = 0;
    int maxl = 0;
    logic w, r, wa, ra;
    for (int c = 0; c < 30 && got < 10; c++) begin
      w = (sent < 10);
      r = (c >= 2) && (mlvl > 0);
      cyc(w, 8'h60 + 8'(sent), r, 1'b0);
      wa = w && (mlvl < 4);
      ra = r && (mlvl > 0);
      mlvl = mlvl + int'(wa) - int'(ra);
      if (wa) sent++;
      checks++;
      if (ra) begin
        if ({rd_valid, rd_data} !== {1'b1, 8'h60 + 8'(got)}) begin
          errors++;
          $display("FAIL stream_data_%0d: rv=%b rd=%h required 1 %h", got, rd_valid, rd_data, 8'h60 + 8'(got));
        end
        got++;
      end else if (rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_idle_%0d: rv=%b required 0", c, rd_valid);
      end
      checks++;
      if (level !== 3'(mlvl)) begin
        errors++;
        $display("FAIL stream_level_%0d: level=%0d required %0d", c, level, mlvl);
      end
      if (int'(level) > maxl) maxl = int'(level);
    end
    checks++;
    if (got != 10 || maxl > 3) begin
      errors++;
      $display("FAIL stream_total: received=%0d maxlevel=%0d required 10 <=3", got, maxl);
    end
  endtask

  task automatic test_clear;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({rd_valid, underflow} !== {1'b0, ERR}) begin
      errors++;
      $display("FAIL clear_pre_underflow: rv=%b un=%b required 0 %b", rd_valid, underflow, ERR);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hCC, 1'b0, 1'b1);
    checks++;
    if ({level, empty, full, almost_full, rd_valid, rd_data, overflow, underflow} !==
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h69, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clear: level=%0d empty=%b full=%b af=%b rv=%b rd=%h ov=%b un=%b required 0 1 0 0 0 69 0 0",
               level, empty, full, almost_full, rd_valid, rd_data, overflow, underflow);
    end
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({rd_valid, rd_data, empty} !== {1'b1, 8'h77, 1'b1}) begin
      errors++;
      $display("FAIL clear_after: rv=%b rd=%h empty=%b required 1 77 1", rd_valid, rd_data, empty);
    end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 8'h81, 1'b0, 1'b0);
    cyc(1'b1, 8'h82, 1'b0, 1'b0);
    cyc(1'b1, 8'h83, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({level, empty, full, almost_full, rd_valid, rd_data, overflow, underflow} !==
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: level=%0d empty=%b full=%b af=%b rv=%b rd=%h ov=%b un=%b required 0 1 0 0 0 00 0 0",
               level, empty, full, almost_full, rd_valid, rd_data, overflow, underflow);
    end
    reset_n = 1'b1;
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({rd_valid, rd_data, level, empty} !== {1'b1, 8'h99, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset_after: rv=%b rd=%h level=%0d empty=%b required 1 99 0 1",
               rd_valid, rd_data, level, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_stream();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
